// File: rtl/coef_mul_stream.sv
// Streaming 12x12 -> 24-bit coefficient multiplier feeding the K-RED stage.
// Two-stage valid/ready pipeline with per-polynomial frame tagging (out_last),
// a one-cycle done pulse after each frame drains, and a sticky range error.
module coef_mul_stream #(
  parameter int W = 12,
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_c,
  output logic           out_last,
  output logic           done,
  output logic           err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [W-1:0]  QW = W'(Q);

  logic clear, en, accept;

  logic           s1_v_q, s1_v_d;
  logic [W-1:0]   s1_a_q, s1_a_d;
  logic [W-1:0]   s1_b_q, s1_b_d;
  logic           s1_last_q, s1_last_d;
  logic           s2_v_q, s2_v_d;
  logic [2*W-1:0] s2_p_q, s2_p_d;
  logic           s2_last_q, s2_last_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [2*W-1:0] prod;

  // Handshake: both stages advance together whenever stage 2 is empty or drained.
  always_comb begin
    clear    = rst | clr;
    en       = !s2_v_q || out_ready;
    in_ready = en && !clear;
    accept   = in_valid && in_ready;
  end

  // Full-width unsigned product; operands zero-extended so nothing truncates.
  always_comb begin
    prod = {{W{1'b0}}, s1_a_q} * {{W{1'b0}}, s1_b_q};
  end

  // Next-state for pipeline stages, frame counter, done pulse and sticky error.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_last_d = s1_last_q;
    s2_v_d    = s2_v_q;
    s2_p_d    = s2_p_q;
    s2_last_d = s2_last_q;
    idx_d     = idx_q;
    if (en) begin
      s1_v_d    = accept;
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_last_d = accept && (idx_q == IDX_LAST);
      s2_v_d    = s1_v_q;
      s2_p_d    = prod;
      s2_last_d = s1_last_q;
    end
    if (accept) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    done_d = s2_v_q && out_ready && s2_last_q;
    err_d  = err_q | (accept && ((in_a >= QW) || (in_b >= QW)));
  end

  // State register; rst and clr both wipe the pipeline and any frame in flight.
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_last_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_p_q    <= '0;
      s2_last_q <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_last_q <= s1_last_d;
      s2_v_q    <= s2_v_d;
      s2_p_q    <= s2_p_d;
      s2_last_q <= s2_last_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Output drive straight from stage 2 so values hold during backpressure.
  always_comb begin
    out_valid = s2_v_q;
    out_c     = s2_p_q;
    out_last  = s2_v_q && s2_last_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_coef_mul_stream.sv
// Self-checking bench for coef_mul_stream: a queue-based reference model
// predicts every transferred product, its last tag, done and err.
module tb_coef_mul_stream;
  localparam int W = 12;
  localparam int N = 256;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic rst, clr, in_valid, in_ready, out_valid, out_ready, out_last, done, err;
  logic [W-1:0] in_a, in_b;
  logic [2*W-1:0] out_c;

  coef_mul_stream #(.W(W), .N(N), .Q(Q)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [24:0] mq[$];
  int  cnt = 0;
  bit  err_m = 0, pend_done = 0;
  // per-cycle observations / expectations
  bit  acc, xf, have, exp_done, exp_err, exp_last;
  logic [23:0] exp_c;
  logic obs_valid, obs_last, obs_done, obs_err, obs_ready;
  logic [23:0] obs_c;
  int  n_out, n_last, n_done;

  // One clock: sample settled outputs mid-cycle, advance the model, cross the edge.
  task automatic cyc();
    logic [24:0] e;
    @(negedge clk);
    obs_valid = out_valid; obs_c = out_c; obs_last = out_last;
    obs_done = done; obs_err = err; obs_ready = in_ready;
    acc = in_valid && in_ready;
    xf  = out_valid && out_ready;
    exp_done = pend_done;
    exp_err  = err_m;
    pend_done = 0;
    have = 0;
    if (xf && mq.size() > 0) begin
      e = mq.pop_front();
      exp_c = e[23:0]; exp_last = e[24]; have = 1; pend_done = e[24];
    end
    if (acc) begin
      mq.push_back({(cnt == N - 1), 24'(int'(in_a) * int'(in_b))});
      cnt = (cnt + 1) % N;
      if (int'(in_a) >= Q || int'(in_b) >= Q) err_m = 1;
    end
    if (rst || clr) begin
      mq.delete(); cnt = 0; err_m = 0; pend_done = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1; in_valid = 0; out_ready = 1;
    cyc();
    clr = 0;
    n_out = 0; n_last = 0; n_done = 0;
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; in_valid = 1; in_a = 12'd5; in_b = 12'd7; out_ready = 1;
    cyc();
    checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", obs_ready); end
    cyc();
    rst = 0; in_valid = 0;
    cyc();
    checks++; if ({obs_valid, obs_last, obs_done, obs_err} !== 4'b0) begin failures++;
      $display("FAIL reset_flags: got valid/last/done/err=%b%b%b%b want 0000", obs_valid, obs_last, obs_done, obs_err); end
    checks++; if (obs_c !== 24'h0) begin failures++; $display("FAIL reset_out_c: got %h want 000000", obs_c); end
  endtask

  task automatic test_latency();
    do_clr();
    in_valid = 1; in_a = 12'd3328; in_b = 12'd3328;
    cyc();
    checks++; if (!acc) begin failures++; $display("FAIL lat_accept: in_ready=%b want 1", obs_ready); end
    in_valid = 0;
    cyc();
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL lat_early: out_valid=%b want 0 one cycle after accept", obs_valid); end
    cyc();
    checks++; if (obs_valid !== 1'b1 || obs_c !== 24'hA90000) begin failures++;
      $display("FAIL lat_product: valid=%b c=%h want 1 a90000", obs_valid, obs_c); end
    checks++; if (!have || obs_c !== exp_c) begin failures++; $display("FAIL lat_model: c=%h want %h", obs_c, exp_c); end
    checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL lat_err: got %b want 0", obs_err); end
    cyc();
    checks++; if (obs_valid !== 1'b0) begin failures++; $display("FAIL lat_dup: out_valid=%b want 0", obs_valid); end
  endtask

  task automatic test_stream();
    int i = 0;
    logic [23:0] last_c = '0;
    int last_pos = -1;
    do_clr();
    out_ready = 1;
    for (int cy = 0; cy < 400 && (i < N || mq.size() > 0 || pend_done); cy++) begin
      in_valid = (i < N); in_a = 12'(i); in_b = 12'(i + 1);
      cyc();
      if (acc) i++;
      if (xf) begin
        n_out++;
        checks++; if (!have || obs_c !== exp_c || obs_last !== exp_last) begin failures++;
          $display("FAIL stream_data: #%0d c=%h last=%b want c=%h last=%b", n_out, obs_c, obs_last, exp_c, exp_last); end
        if (obs_last) begin n_last++; last_c = obs_c; last_pos = n_out; end
      end
      if (obs_done) n_done++;
      checks++; if (obs_done !== exp_done) begin failures++; $display("FAIL stream_done: got %b want %b", obs_done, exp_done); end
    end
    checks++; if (n_out != N || n_last != 1 || last_pos != N || last_c !== 24'd65280) begin failures++;
      $display("FAIL stream_frame: outs=%0d lasts=%0d pos=%0d c=%0d want 256 1 256 65280", n_out, n_last, last_pos, last_c); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL stream_done_count: got %0d want 1", n_done); end
    checks++; if (dut.idx_q !== 8'd0) begin failures++; $display("FAIL stream_idx: got %0d want 0", dut.idx_q); end
  endtask

  task automatic test_stall();
    int i = 0;
    logic [23:0] hold_c = '0;
    do_clr();
    in_a = 12'($urandom_range(0, Q - 1)); in_b = 12'($urandom_range(0, Q - 1));
    for (int cy = 0; cy < 200 && (i < 40 || mq.size() > 0); cy++) begin
      in_valid = (i < 40);
      out_ready = !(cy >= 10 && cy < 15);
      cyc();
      if (acc) begin i++; in_a = 12'($urandom_range(0, Q - 1)); in_b = 12'($urandom_range(0, Q - 1)); end
      if (cy >= 10 && cy < 15) begin
        if (cy == 10) hold_c = obs_c;
        checks++; if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_c !== hold_c) begin failures++;
          $display("FAIL stall_hold: cy=%0d ready=%b valid=%b c=%h want 0 1 %h", cy, obs_ready, obs_valid, obs_c, hold_c); end
      end
      if (xf) begin
        n_out++;
        checks++; if (!have || obs_c !== exp_c || obs_last !== exp_last) begin failures++;
          $display("FAIL stall_data: #%0d c=%h want %h", n_out, obs_c, exp_c); end
      end
    end
    checks++; if (n_out != 40) begin failures++; $display("FAIL stall_count: got %0d want 40", n_out); end
  endtask

  task automatic test_err();
    int i = 0;
    do_clr();
    in_valid = 1; in_a = 12'd3329; in_b = 12'd1;
    cyc();
    in_valid = 0;
    for (int cy = 0; cy < 5; cy++) begin
      cyc();
      if (xf) begin
        checks++; if (!have || obs_c !== 24'd3329) begin failures++; $display("FAIL err_product: c=%0d want 3329", obs_c); end
      end
    end
    checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", obs_err); end
    for (int cy = 0; cy < 400 && (i < N || mq.size() > 0); cy++) begin
      in_valid = (i < N); out_ready = ($urandom_range(0, 3) != 0);
      in_a = 12'($urandom_range(0, Q - 1)); in_b = 12'($urandom_range(0, Q - 1));
      cyc();
      if (acc) i++;
      checks++; if (obs_err !== 1'b1 || obs_err !== exp_err) begin failures++; $display("FAIL err_sticky: got %b want 1", obs_err); end
    end
    do_clr();
    cyc();
    checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", obs_err); end
  endtask

  task automatic test_clr_mid();
    int i = 0;
    do_clr();
    out_ready = 1;
    for (int cy = 0; cy < 200 && i < 100; cy++) begin
      in_valid = 1; in_a = 12'($urandom_range(0, Q - 1)); in_b = 12'($urandom_range(0, Q - 1));
      cyc();
      if (acc) i++;
    end
    clr = 1; in_valid = 1;
    cyc();
    checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready: got %b want 0", obs_ready); end
    clr = 0; in_valid = 0;
    cyc();
    checks++; if (obs_valid !== 1'b0 || obs_done !== 1'b0) begin failures++;
      $display("FAIL clr_flush: valid=%b done=%b want 0 0", obs_valid, obs_done); end
    i = 0; n_out = 0; n_last = 0; n_done = 0;
    for (int cy = 0; cy < 400 && (i < N || mq.size() > 0 || pend_done); cy++) begin
      in_valid = (i < N); in_a = 12'($urandom_range(0, Q - 1)); in_b = 12'($urandom_range(0, Q - 1));
      cyc();
      if (acc) i++;
      if (obs_done) n_done++;
      if (xf) begin
        n_out++;
        if (obs_last) n_last++;
        checks++; if (!have || obs_c !== exp_c || obs_last !== exp_last || obs_last !== (n_out == N)) begin failures++;
          $display("FAIL clr_frame: #%0d c=%h last=%b want c=%h last=%b", n_out, obs_c, obs_last, exp_c, (n_out == N)); end
      end
      checks++; if (obs_done !== exp_done) begin failures++; $display("FAIL clr_done: got %b want %b", obs_done, exp_done); end
    end
    checks++; if (n_out != N || n_last != 1 || n_done != 1) begin failures++;
      $display("FAIL clr_frame_count: outs=%0d lasts=%0d dones=%0d want 256 1 1", n_out, n_last, n_done); end
  endtask

  task automatic test_random();
    do_clr();
    for (int cy = 0; cy < 1500; cy++) begin
      in_valid  = (cy < 1400) && ($urandom_range(0, 3) != 0);
      out_ready = (cy >= 1400) || ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 63) == 0) in_a = 12'($urandom_range(Q, 4095));
      else in_a = 12'($urandom_range(0, Q - 1));
      in_b = 12'($urandom_range(0, Q - 1));
      cyc();
      if (xf) begin
        checks++; if (!have || obs_c !== exp_c || obs_last !== exp_last) begin failures++;
          $display("FAIL rand_data: cy=%0d c=%h last=%b want c=%h last=%b", cy, obs_c, obs_last, exp_c, exp_last); end
      end
      checks++; if (obs_done !== exp_done || obs_err !== exp_err) begin failures++;
        $display("FAIL rand_flags: cy=%0d done=%b err=%b want %b %b", cy, obs_done, obs_err, exp_done, exp_err); end
    end
    checks++; if (mq.size() != 0) begin failures++; $display("FAIL rand_drain: %0d products never emitted", mq.size()); end
  endtask

  task automatic test_rst_mid();
    do_clr();
    in_valid = 1; in_a = 12'd11; in_b = 12'd13;
    cyc(); cyc();
    rst = 1; in_valid = 1;
    cyc();
    checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", obs_ready); end
    rst = 0; in_valid = 0;
    cyc();
    checks++; if ({obs_valid, obs_last, obs_done, obs_err} !== 4'b0 || obs_c !== 24'h0) begin failures++;
      $display("FAIL rst_outputs: valid=%b last=%b done=%b err=%b c=%h want all 0", obs_valid, obs_last, obs_done, obs_err, obs_c); end
    checks++; if (dut.idx_q !== 8'd0) begin failures++; $display("FAIL rst_idx: got %0d want 0", dut.idx_q); end
  endtask

  initial begin
    rst = 1; clr = 0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 1;
    #1;
    test_reset();
    test_latency();
    test_stream();
    test_stall();
    test_err();
    test_clr_mid();
    test_random();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
